// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if: rename-side handshake bundle between the free list and its rename/commit/checkpoint clients.
interface phys_reg_free_list_if #(
    parameter int NUM_PHYS_REGS      = 64,
    parameter int NUM_ARCH_REGS      = 32,
    parameter int CHECKPOINT_COLUMNS = 4
);
    localparam int FREE_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int TAG_W      = $clog2(NUM_PHYS_REGS);
    localparam int COL_W      = $clog2(CHECKPOINT_COLUMNS);
    localparam int CNT_W      = $clog2(FREE_DEPTH) + 1;

    logic             dequeue_valid;
    logic             dequeue_ready;
    logic [TAG_W-1:0] dequeue_phys_reg_tag;
    logic             commit_enqueue_valid;
    logic [TAG_W-1:0] commit_enqueue_phys_reg_tag;
    logic             revert_valid;
    logic [TAG_W-1:0] revert_phys_reg_tag;
    logic             save_checkpoint_valid;
    logic [COL_W-1:0] save_checkpoint_column;
    logic             restore_checkpoint_valid;
    logic             restore_checkpoint_speculate_failed;
    logic [COL_W-1:0] restore_checkpoint_column;
    logic [CNT_W-1:0] free_count;

    modport master (
        output dequeue_valid, commit_enqueue_valid, commit_enqueue_phys_reg_tag,
               revert_valid, revert_phys_reg_tag, save_checkpoint_valid, save_checkpoint_column,
               restore_checkpoint_valid, restore_checkpoint_speculate_failed, restore_checkpoint_column,
        input  dequeue_ready, dequeue_phys_reg_tag, free_count
    );

    modport slave (
        input  dequeue_valid, commit_enqueue_valid, commit_enqueue_phys_reg_tag,
               revert_valid, revert_phys_reg_tag, save_checkpoint_valid, save_checkpoint_column,
               restore_checkpoint_valid, restore_checkpoint_speculate_failed, restore_checkpoint_column,
        output dequeue_ready, dequeue_phys_reg_tag, free_count
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical register tags with revert and per-checkpoint head snapshots.
module phys_reg_free_list #(
    parameter int NUM_PHYS_REGS      = 64,
    parameter int NUM_ARCH_REGS      = 32,
    parameter int CHECKPOINT_COLUMNS = 4,
    parameter bit CHECK_EN           = 1'b1
) (
    input logic CLK,
    input logic RST,
    phys_reg_free_list_if.slave fl
);
    localparam int FREE_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int IDX_W      = $clog2(FREE_DEPTH);
    localparam int PTR_W      = IDX_W + 1;
    localparam int TAG_W      = $clog2(NUM_PHYS_REGS);
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(FREE_DEPTH);

    logic [TAG_W-1:0]              entries [FREE_DEPTH];
    logic [PTR_W-1:0]              snap_head [CHECKPOINT_COLUMNS];
    logic [CHECKPOINT_COLUMNS-1:0] snap_valid, snap_valid_next;
    logic [PTR_W-1:0]              head_ptr, tail_ptr, head_next, tail_next, head_dec, count;
    logic                          empty, full, head_busy;
    logic                          deq_ok, enq_ok, revert_ok, save_ok;
    logic                          restore_fail, restore_discard, restore_ok;
    logic                          revert_mismatch;
    logic                          protocol_error;

    // Wrap-bit pointers: count is a plain modular difference, full and empty need no extra flag.
    assign count    = tail_ptr - head_ptr;
    assign empty    = count == '0;
    assign full     = count == DEPTH_PTR;
    assign head_dec = head_ptr - PTR_W'(1);

    // Revert and restore own the head pointer; save and dequeue only act when neither is present.
    assign head_busy       = fl.revert_valid | fl.restore_checkpoint_valid;
    assign revert_ok       = fl.revert_valid & ~full;
    assign restore_fail    = fl.restore_checkpoint_valid & ~fl.revert_valid & fl.restore_checkpoint_speculate_failed;
    assign restore_discard = fl.restore_checkpoint_valid & ~fl.revert_valid & ~fl.restore_checkpoint_speculate_failed;
    assign restore_ok      = restore_fail & snap_valid[fl.restore_checkpoint_column];
    assign deq_ok          = fl.dequeue_valid & ~empty & ~head_busy;
    assign save_ok         = fl.save_checkpoint_valid & ~head_busy;
    // A dequeue in the same cycle frees the head slot, so a full list still accepts the enqueue.
    assign enq_ok          = fl.commit_enqueue_valid & (~full | deq_ok);
    assign revert_mismatch = entries[head_dec[IDX_W-1:0]] != fl.revert_phys_reg_tag;

    always_comb begin
        head_next = revert_ok ? head_dec :
                    restore_ok ? snap_head[fl.restore_checkpoint_column] :
                    deq_ok ? head_ptr + PTR_W'(1) : head_ptr;
        tail_next = enq_ok ? tail_ptr + PTR_W'(1) : tail_ptr;
    end

    always_comb begin
        snap_valid_next = snap_valid;
        if (restore_ok)
            snap_valid_next = '0;
        else if (restore_discard)
            snap_valid_next[fl.restore_checkpoint_column] = 1'b0;
        else if (save_ok)
            snap_valid_next[fl.save_checkpoint_column] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_ptr   <= '0;
            tail_ptr   <= DEPTH_PTR;
            snap_valid <= '0;
        end else begin
            head_ptr   <= head_next;
            tail_ptr   <= tail_next;
            snap_valid <= snap_valid_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FREE_DEPTH; i++)
                entries[i] <= TAG_W'(NUM_ARCH_REGS + i);
        end else begin
            if (enq_ok)
                entries[tail_ptr[IDX_W-1:0]] <= fl.commit_enqueue_phys_reg_tag;
            if (revert_ok)
                entries[head_dec[IDX_W-1:0]] <= fl.revert_phys_reg_tag;
        end
    end

    // Snapshot heads are qualified by snap_valid, so they need no reset.
    always_ff @(posedge CLK) begin
        if (save_ok)
            snap_head[fl.save_checkpoint_column] <= head_ptr;
    end

    assign fl.dequeue_ready        = ~empty;
    assign fl.dequeue_phys_reg_tag = entries[head_ptr[IDX_W-1:0]];
    assign fl.free_count           = count;

    assign protocol_error = (fl.dequeue_valid & empty)
                          | (fl.commit_enqueue_valid & full & ~deq_ok)
                          | (fl.revert_valid & (full | revert_mismatch))
                          | (restore_fail & ~snap_valid[fl.restore_checkpoint_column]);

    if (CHECK_EN) begin : g_chk
        always_ff @(posedge CLK) begin
            if (!RST) begin
                assert (!(fl.dequeue_valid & empty))
                    else $error("phys_reg_free_list: dequeue while empty");
                assert (!(fl.commit_enqueue_valid & full & ~deq_ok))
                    else $error("phys_reg_free_list: enqueue while full dropped");
                assert (!(fl.revert_valid & full))
                    else $error("phys_reg_free_list: revert while full");
                assert (!(fl.revert_valid & ~full & revert_mismatch))
                    else $error("phys_reg_free_list: revert tag differs from speculated entry");
                assert (!(restore_fail & ~snap_valid[fl.restore_checkpoint_column]))
                    else $error("phys_reg_free_list: restore from invalid snapshot");
            end
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed scenarios plus randomized traffic against a queue-based free-list model.
module tb_phys_reg_free_list;
    logic CLK = 1'b0;
    logic RST;
    int checks = 0;
    int errors = 0;

    int fl_q[$];
    int taken[$];
    bit [3:0] sv;
    int st[4];

    always #5 CLK = ~CLK;

    phys_reg_free_list_if fl_if();

    phys_reg_free_list #(.CHECK_EN(1'b0)) dut (
        .CLK(CLK),
        .RST(RST),
        .fl(fl_if)
    );

    task automatic idle();
        fl_if.dequeue_valid = 0;
        fl_if.commit_enqueue_valid = 0;
        fl_if.commit_enqueue_phys_reg_tag = '0;
        fl_if.revert_valid = 0;
        fl_if.revert_phys_reg_tag = '0;
        fl_if.save_checkpoint_valid = 0;
        fl_if.save_checkpoint_column = '0;
        fl_if.restore_checkpoint_valid = 0;
        fl_if.restore_checkpoint_speculate_failed = 0;
        fl_if.restore_checkpoint_column = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RST = 1;
        tick();
        RST = 0;
        fl_q.delete();
        for (int i = 0; i < 32; i++) fl_q.push_back(32 + i);
        taken.delete();
        sv = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fl_if.dequeue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", fl_if.dequeue_ready); end
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd32) begin errors++; $display("FAIL reset_tag got %0d want 32", fl_if.dequeue_phys_reg_tag); end
        checks++; if (fl_if.free_count !== 6'd32) begin errors++; $display("FAIL reset_count got %0d want 32", fl_if.free_count); end
    endtask

    task automatic test_dequeue_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (fl_if.dequeue_phys_reg_tag !== 6'(32 + i)) begin errors++; $display("FAIL deq_tag%0d got %0d want %0d", i, fl_if.dequeue_phys_reg_tag, 32 + i); end
            fl_if.dequeue_valid = 1;
            tick();
            checks++; if (fl_if.free_count !== 6'(31 - i)) begin errors++; $display("FAIL deq_count%0d got %0d want %0d", i, fl_if.free_count, 31 - i); end
            checks++; if (fl_if.dequeue_ready !== 1'b1) begin errors++; $display("FAIL deq_ready%0d got %0b want 1", i, fl_if.dequeue_ready); end
        end
        idle();
    endtask

    task automatic test_drain_refill();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            checks++; if (fl_if.dequeue_phys_reg_tag !== 6'(32 + i)) begin errors++; $display("FAIL drain_tag%0d got %0d want %0d", i, fl_if.dequeue_phys_reg_tag, 32 + i); end
            fl_if.dequeue_valid = 1;
            tick();
        end
        idle();
        checks++; if (fl_if.dequeue_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got %0b want 0", fl_if.dequeue_ready); end
        checks++; if (fl_if.free_count !== 6'd0) begin errors++; $display("FAIL drain_count got %0d want 0", fl_if.free_count); end
        fl_if.dequeue_valid = 1;
        fl_if.commit_enqueue_valid = 1;
        fl_if.commit_enqueue_phys_reg_tag = 6'd5;
        #1;
        checks++; if (dut.protocol_error !== 1'b1) begin errors++; $display("FAIL empty_deq_flag got %0b want 1", dut.protocol_error); end
        tick();
        idle();
        checks++; if (fl_if.dequeue_ready !== 1'b1) begin errors++; $display("FAIL refill_ready got %0b want 1", fl_if.dequeue_ready); end
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd5) begin errors++; $display("FAIL refill_tag got %0d want 5", fl_if.dequeue_phys_reg_tag); end
        checks++; if (fl_if.free_count !== 6'd1) begin errors++; $display("FAIL refill_count got %0d want 1", fl_if.free_count); end
    endtask

    task automatic test_restore();
        do_reset();
        fl_if.dequeue_valid = 1;
        tick();
        tick();
        fl_if.save_checkpoint_valid = 1;
        fl_if.save_checkpoint_column = 2'd1;
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd34) begin errors++; $display("FAIL save_tag got %0d want 34", fl_if.dequeue_phys_reg_tag); end
        tick();
        fl_if.save_checkpoint_column = 2'd2;
        tick();
        fl_if.save_checkpoint_valid = 0;
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd36) begin errors++; $display("FAIL spec_tag got %0d want 36", fl_if.dequeue_phys_reg_tag); end
        tick();
        tick();
        idle();
        fl_if.commit_enqueue_valid = 1;
        fl_if.commit_enqueue_phys_reg_tag = 6'd7;
        tick();
        idle();
        checks++; if (fl_if.free_count !== 6'd27) begin errors++; $display("FAIL spec_count got %0d want 27", fl_if.free_count); end
        fl_if.restore_checkpoint_valid = 1;
        fl_if.restore_checkpoint_speculate_failed = 1;
        fl_if.restore_checkpoint_column = 2'd1;
        fl_if.dequeue_valid = 1;
        tick();
        idle();
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd34) begin errors++; $display("FAIL restore_tag got %0d want 34", fl_if.dequeue_phys_reg_tag); end
        checks++; if (fl_if.free_count !== 6'd31) begin errors++; $display("FAIL restore_count got %0d want 31", fl_if.free_count); end
        fl_if.restore_checkpoint_valid = 1;
        fl_if.restore_checkpoint_speculate_failed = 1;
        fl_if.restore_checkpoint_column = 2'd2;
        #1;
        checks++; if (dut.protocol_error !== 1'b1) begin errors++; $display("FAIL stale_snap_flag got %0b want 1", dut.protocol_error); end
        tick();
        idle();
        checks++; if (fl_if.free_count !== 6'd31) begin errors++; $display("FAIL stale_snap_count got %0d want 31", fl_if.free_count); end
        fl_if.save_checkpoint_valid = 1;
        fl_if.save_checkpoint_column = 2'd0;
        fl_if.dequeue_valid = 1;
        tick();
        idle();
        fl_if.restore_checkpoint_valid = 1;
        fl_if.restore_checkpoint_column = 2'd0;
        tick();
        idle();
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd35) begin errors++; $display("FAIL discard_tag got %0d want 35", fl_if.dequeue_phys_reg_tag); end
        fl_if.restore_checkpoint_valid = 1;
        fl_if.restore_checkpoint_speculate_failed = 1;
        fl_if.restore_checkpoint_column = 2'd0;
        tick();
        idle();
        checks++; if (fl_if.free_count !== 6'd30) begin errors++; $display("FAIL discard_count got %0d want 30", fl_if.free_count); end
    endtask

    task automatic test_revert();
        do_reset();
        fl_if.dequeue_valid = 1;
        tick();
        idle();
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd33) begin errors++; $display("FAIL pre_revert_tag got %0d want 33", fl_if.dequeue_phys_reg_tag); end
        fl_if.revert_valid = 1;
        fl_if.revert_phys_reg_tag = 6'd32;
        fl_if.dequeue_valid = 1;
        #1;
        checks++; if (dut.protocol_error !== 1'b0) begin errors++; $display("FAIL revert_ok_flag got %0b want 0", dut.protocol_error); end
        tick();
        idle();
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd32) begin errors++; $display("FAIL revert_tag got %0d want 32", fl_if.dequeue_phys_reg_tag); end
        checks++; if (fl_if.free_count !== 6'd32) begin errors++; $display("FAIL revert_count got %0d want 32", fl_if.free_count); end
        fl_if.revert_valid = 1;
        fl_if.revert_phys_reg_tag = 6'd40;
        tick();
        idle();
        checks++; if (fl_if.free_count !== 6'd32) begin errors++; $display("FAIL revert_full_count got %0d want 32", fl_if.free_count); end
        fl_if.dequeue_valid = 1;
        tick();
        idle();
        fl_if.revert_valid = 1;
        fl_if.revert_phys_reg_tag = 6'd40;
        #1;
        checks++; if (dut.protocol_error !== 1'b1) begin errors++; $display("FAIL revert_mismatch_flag got %0b want 1", dut.protocol_error); end
        tick();
        idle();
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd40) begin errors++; $display("FAIL revert_mismatch_tag got %0d want 40", fl_if.dequeue_phys_reg_tag); end
    endtask

    task automatic test_full_enq_deq();
        do_reset();
        fl_if.commit_enqueue_valid = 1;
        fl_if.commit_enqueue_phys_reg_tag = 6'd11;
        #1;
        checks++; if (dut.protocol_error !== 1'b1) begin errors++; $display("FAIL full_enq_flag got %0b want 1", dut.protocol_error); end
        tick();
        idle();
        checks++; if (fl_if.free_count !== 6'd32) begin errors++; $display("FAIL full_drop_count got %0d want 32", fl_if.free_count); end
        fl_if.commit_enqueue_valid = 1;
        fl_if.commit_enqueue_phys_reg_tag = 6'd9;
        fl_if.dequeue_valid = 1;
        tick();
        idle();
        checks++; if (fl_if.free_count !== 6'd32) begin errors++; $display("FAIL full_both_count got %0d want 32", fl_if.free_count); end
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd33) begin errors++; $display("FAIL full_both_tag got %0d want 33", fl_if.dequeue_phys_reg_tag); end
        fl_if.dequeue_valid = 1;
        for (int i = 0; i < 31; i++) tick();
        idle();
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd9) begin errors++; $display("FAIL wrap_tail_tag got %0d want 9", fl_if.dequeue_phys_reg_tag); end
        checks++; if (fl_if.free_count !== 6'd1) begin errors++; $display("FAIL wrap_tail_count got %0d want 1", fl_if.free_count); end
    endtask

    task automatic test_random();
        int op, col, mn, mx, pre_size, t;
        bit pre_full;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            idle();
            op = $urandom_range(0, 9);
            col = $urandom_range(0, 3);
            pre_size = fl_q.size();
            pre_full = pre_size == 32;
            mx = 0;
            for (int c = 0; c < 4; c++) if (sv[c] && st[c] > mx) mx = st[c];
            if (op <= 3) begin
                fl_if.dequeue_valid = 1;
                if (fl_q.size() > 0) taken.push_back(fl_q.pop_front());
            end else if (op == 4) begin
                fl_if.save_checkpoint_valid = 1;
                fl_if.save_checkpoint_column = 2'(col);
                sv[col] = 1;
                st[col] = taken.size();
                if ($urandom_range(0, 1) == 1) begin
                    fl_if.dequeue_valid = 1;
                    if (fl_q.size() > 0) taken.push_back(fl_q.pop_front());
                end
            end else if (op == 5) begin
                if (taken.size() > mx && !pre_full) begin
                    t = taken.pop_back();
                    fl_if.revert_valid = 1;
                    fl_if.revert_phys_reg_tag = 6'(t);
                    fl_q.push_front(t);
                end
            end else if (op == 6) begin
                fl_if.restore_checkpoint_valid = 1;
                fl_if.restore_checkpoint_speculate_failed = 1;
                fl_if.restore_checkpoint_column = 2'(col);
                if (sv[col]) begin
                    while (taken.size() > st[col]) fl_q.push_front(taken.pop_back());
                    sv = '0;
                end
            end else if (op == 7) begin
                fl_if.restore_checkpoint_valid = 1;
                fl_if.restore_checkpoint_column = 2'(col);
                sv[col] = 0;
            end
            mn = taken.size();
            for (int c = 0; c < 4; c++) if (sv[c] && st[c] < mn) mn = st[c];
            t = $urandom_range(0, 63);
            if (fl_q.size() + (taken.size() - mn) < 32 && $urandom_range(0, 1) == 1) begin
                fl_if.commit_enqueue_valid = 1;
                fl_if.commit_enqueue_phys_reg_tag = 6'(t);
                fl_q.push_back(t);
            end else if (pre_full && fl_q.size() == 32 && $urandom_range(0, 3) == 0) begin
                fl_if.commit_enqueue_valid = 1;
                fl_if.commit_enqueue_phys_reg_tag = 6'(t);
            end
            tick();
            checks++; if (fl_if.free_count !== 6'(fl_q.size())) begin errors++; $display("FAIL rand_count cyc%0d got %0d want %0d", cyc, fl_if.free_count, fl_q.size()); end
            checks++; if (fl_if.dequeue_ready !== (fl_q.size() > 0)) begin errors++; $display("FAIL rand_ready cyc%0d got %0b want %0b", cyc, fl_if.dequeue_ready, fl_q.size() > 0); end
            if (fl_q.size() > 0) begin
                checks++; if (fl_if.dequeue_phys_reg_tag !== 6'(fl_q[0])) begin errors++; $display("FAIL rand_tag cyc%0d got %0d want %0d", cyc, fl_if.dequeue_phys_reg_tag, fl_q[0]); end
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        fl_if.save_checkpoint_valid = 1;
        fl_if.save_checkpoint_column = 2'd0;
        fl_if.dequeue_valid = 1;
        tick();
        fl_if.save_checkpoint_valid = 0;
        for (int i = 0; i < 9; i++) tick();
        idle();
        checks++; if (fl_if.free_count !== 6'd22) begin errors++; $display("FAIL pre_rst_count got %0d want 22", fl_if.free_count); end
        RST = 1;
        #1;
        checks++; if (fl_if.free_count !== 6'd32) begin errors++; $display("FAIL async_rst_count got %0d want 32", fl_if.free_count); end
        checks++; if (fl_if.dequeue_phys_reg_tag !== 6'd32) begin errors++; $display("FAIL async_rst_tag got %0d want 32", fl_if.dequeue_phys_reg_tag); end
        checks++; if (fl_if.dequeue_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready got %0b want 1", fl_if.dequeue_ready); end
        tick();
        RST = 0;
        fl_if.restore_checkpoint_valid = 1;
        fl_if.restore_checkpoint_speculate_failed = 1;
        fl_if.restore_checkpoint_column = 2'd0;
        #1;
        checks++; if (dut.protocol_error !== 1'b1) begin errors++; $display("FAIL rst_snap_flag got %0b want 1", dut.protocol_error); end
        tick();
        idle();
        checks++; if (fl_if.free_count !== 6'd32) begin errors++; $display("FAIL rst_snap_count got %0d want 32", fl_if.free_count); end
    endtask

    initial begin
        RST = 1;
        idle();
        test_reset();
        test_dequeue_order();
        test_drain_refill();
        test_restore();
        test_revert();
        test_full_enq_deq();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
